// File: rtl/histogram_bank_if.sv
// Pixel-stream and bin-readout bundle for histogram_bank.
// slave = histogram block view, master = pixel source / readout consumer view.
interface histogram_bank_if #(
  parameter int DATA_W   = 8,
  parameter int BIN_BITS = 8,
  parameter int COUNT_W  = 16,
  parameter int TOTAL_W  = COUNT_W + BIN_BITS
);
  logic                i_valid;
  logic [DATA_W-1:0]   i_data;
  logic                i_last;
  logic                o_ready;
  logic                o_bin_valid;
  logic [BIN_BITS-1:0] o_bin_index;
  logic [COUNT_W-1:0]  o_bin_count;
  logic                o_bin_last;
  logic                i_bin_ready;
  logic [TOTAL_W-1:0]  o_total;
  logic                o_overflow;

  modport slave (
    input  i_valid, i_data, i_last, i_bin_ready,
    output o_ready, o_bin_valid, o_bin_index, o_bin_count, o_bin_last,
           o_total, o_overflow
  );

  modport master (
    output i_valid, i_data, i_last, i_bin_ready,
    input  o_ready, o_bin_valid, o_bin_index, o_bin_count, o_bin_last,
           o_total, o_overflow
  );
endinterface

// File: rtl/histogram_bank.sv
// histogram_bank: per-frame intensity histogram with read-and-clear readout.
// Pixels are binned on their top BIN_BITS bits while accumulating; after the
// frame's last pixel every bin is streamed out once, and each bin is zeroed
// as its beat is accepted so the next frame starts from a clean array.
// Optional feature macro: HIST_SATURATE_EN (saturating bins + sticky
// overflow flag). Without it bins wrap and o_overflow is tied low.
module histogram_bank #(
  parameter int DATA_W   = 8,
  parameter int BIN_BITS = 8,
  parameter int COUNT_W  = 16,
  parameter int TOTAL_W  = COUNT_W + BIN_BITS
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  histogram_bank_if.slave  bus
);

  localparam int NUM_BINS = 1 << BIN_BITS;

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_READ  = 1'b1
  } state_t;

  state_t              state_q;
  logic                ready_q;
  logic                bin_valid_q;
  logic                bin_last_q;
  logic [BIN_BITS-1:0] ptr_q;
  logic [BIN_BITS-1:0] ptr_d;
  logic [COUNT_W-1:0]  count_q;
  logic [TOTAL_W-1:0]  total_q;
  logic [COUNT_W-1:0]  hist_q [NUM_BINS];

  logic [BIN_BITS-1:0] sel;
  logic                accept;
  logic                rd_hs;
  // Low intensity bits below the bin field are intentionally ignored.
  logic                unused_data;

  // Next count of a bin that takes a hit: wraps, or sticks at full scale.
  function automatic logic [COUNT_W-1:0] bump(input logic [COUNT_W-1:0] c);
`ifdef HIST_SATURATE_EN
    bump = (&c) ? c : c + COUNT_W'(1);
`else
    bump = c + COUNT_W'(1);
`endif
  endfunction

  assign sel         = bus.i_data[DATA_W-1 -: BIN_BITS];
  assign unused_data = ^bus.i_data;
  // ready_q is only ever high in S_ACCUM, bin_valid_q only in S_READ, so the
  // pixel and readout handshakes can never coincide.
  assign accept      = bus.i_valid && ready_q;
  assign rd_hs       = bin_valid_q && bus.i_bin_ready;
  assign ptr_d       = ptr_q + BIN_BITS'(1);

`ifdef HIST_SATURATE_EN
  logic ovf_q;
  logic sat_hit;
  assign sat_hit        = accept && (&hist_q[sel]);
  assign bus.o_overflow = ovf_q;
`else
  assign bus.o_overflow = 1'b0;
`endif

  assign bus.o_ready     = ready_q;
  assign bus.o_bin_valid = bin_valid_q;
  assign bus.o_bin_index = ptr_q;
  assign bus.o_bin_count = count_q;
  assign bus.o_bin_last  = bin_last_q;
  assign bus.o_total     = total_q;

  // Bin array: count accepted pixels, clear each bin as its readout beat is taken.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int b = 0; b < NUM_BINS; b++) begin
        hist_q[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BINS; b++) begin
        if (accept && (sel == BIN_BITS'(b))) begin
          hist_q[b] <= bump(hist_q[b]);
        end else if (rd_hs && (ptr_q == BIN_BITS'(b))) begin
          hist_q[b] <= '0;
        end
      end
    end
  end

  // Control FSM: accumulate a frame, then present one registered bin per beat.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_ACCUM;
      ready_q     <= 1'b0;
      bin_valid_q <= 1'b0;
      bin_last_q  <= 1'b0;
      ptr_q       <= '0;
      count_q     <= '0;
      total_q     <= '0;
`ifdef HIST_SATURATE_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_ACCUM: begin
          ready_q <= 1'b1;
          if (accept) begin
            total_q <= total_q + TOTAL_W'(1);
`ifdef HIST_SATURATE_EN
            if (sat_hit) begin
              ovf_q <= 1'b1;
            end
`endif
            if (bus.i_last) begin
              state_q <= S_READ;
              ready_q <= 1'b0;
              ptr_q   <= '0;
            end
          end
        end

        S_READ: begin
          if (!bin_valid_q) begin
            // First readout cycle: the last pixel's bin update has landed.
            bin_valid_q <= 1'b1;
            count_q     <= hist_q[ptr_q];
            bin_last_q  <= (ptr_q == {BIN_BITS{1'b1}});
          end else if (rd_hs) begin
            if (bin_last_q) begin
              state_q     <= S_ACCUM;
              ready_q     <= 1'b1;
              bin_valid_q <= 1'b0;
              bin_last_q  <= 1'b0;
              ptr_q       <= '0;
              count_q     <= '0;
              total_q     <= '0;
`ifdef HIST_SATURATE_EN
              ovf_q       <= 1'b0;
`endif
            end else begin
              // Prefetch the next bin; only hist_q[ptr_q] is cleared this edge.
              ptr_q      <= ptr_d;
              count_q    <= hist_q[ptr_d];
              bin_last_q <= (ptr_d == {BIN_BITS{1'b1}});
            end
          end
        end

        default: begin
          state_q <= S_ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_histogram_bank.sv
// Directed bench for histogram_bank: default geometry, a 16-bin instance and
// a 4-bit-counter instance, each with hand-computed bin contents.
module tb_histogram_bank;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  histogram_bank_if #(.DATA_W(8), .BIN_BITS(8), .COUNT_W(16), .TOTAL_W(24)) m_if ();
  histogram_bank_if #(.DATA_W(8), .BIN_BITS(4), .COUNT_W(16), .TOTAL_W(20)) b_if ();
  histogram_bank_if #(.DATA_W(8), .BIN_BITS(8), .COUNT_W(4),  .TOTAL_W(12)) c_if ();

  histogram_bank #(.DATA_W(8), .BIN_BITS(8), .COUNT_W(16), .TOTAL_W(24)) u_main (
    .i_clk(clk), .i_reset_n(rst_n), .bus(m_if));
  histogram_bank #(.DATA_W(8), .BIN_BITS(4), .COUNT_W(16), .TOTAL_W(20)) u_b4 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(b_if));
  histogram_bank #(.DATA_W(8), .BIN_BITS(8), .COUNT_W(4),  .TOTAL_W(12)) u_c4 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(c_if));

  int n_cmp = 0;
  int n_bad = 0;

  // Readout capture of the main instance.
  logic [31:0] got_cnt [256];
  logic [31:0] got_idx [256];
  logic        got_last[256];
  logic [31:0] got_tot [256];
  logic [31:0] exp_cnt [256];
  int          nbeats, first_cyc, last_cyc;
  bit          stall_moved, ready_seen, timed_out;

  task automatic clear_exp();
    for (int b = 0; b < 256; b++) exp_cnt[b] = 32'd0;
  endtask

  task automatic pix(input logic [7:0] v, input bit last);
    m_if.i_valid = 1'b1;
    m_if.i_data  = v;
    m_if.i_last  = last;
    @(posedge clk); #1;
    m_if.i_valid = 1'b0;
    m_if.i_last  = 1'b0;
  endtask

  // Collect one full readout; stall_pat applies i_bin_ready = 1,0,0,1,...
  task automatic capture_main(input bit stall_pat);
    int   cyc;
    bit   done, pv, pr;
    logic [7:0]  pidx;
    logic [15:0] pcnt;
    logic        plast;
    logic [23:0] ptot;
    for (int b = 0; b < 256; b++) begin
      got_cnt[b] = 'x; got_idx[b] = 'x; got_last[b] = 1'bx; got_tot[b] = 'x;
    end
    nbeats = 0; first_cyc = -1; last_cyc = -1;
    stall_moved = 0; ready_seen = 0; done = 0; pv = 0; pr = 1; cyc = 0;
    pidx = '0; pcnt = '0; plast = 1'b0; ptot = '0;
    while (!done && cyc < 2000 && nbeats < 300) begin
      m_if.i_bin_ready = stall_pat ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (m_if.o_ready !== 1'b0) ready_seen = 1;
      if (pv && !pr) begin
        if (m_if.o_bin_valid !== 1'b1 || m_if.o_bin_index !== pidx ||
            m_if.o_bin_count !== pcnt || m_if.o_bin_last !== plast ||
            m_if.o_total !== ptot) stall_moved = 1;
      end
      if (m_if.o_bin_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (m_if.i_bin_ready) begin
          if (nbeats < 256) begin
            got_cnt[nbeats]  = 32'(m_if.o_bin_count);
            got_idx[nbeats]  = 32'(m_if.o_bin_index);
            got_last[nbeats] = m_if.o_bin_last;
            got_tot[nbeats]  = 32'(m_if.o_total);
          end
          nbeats++;
          last_cyc = cyc;
          if (m_if.o_bin_last === 1'b1) done = 1;
        end
      end
      pv = (m_if.o_bin_valid === 1'b1); pr = m_if.i_bin_ready;
      pidx = m_if.o_bin_index; pcnt = m_if.o_bin_count;
      plast = m_if.o_bin_last; ptot = m_if.o_total;
      @(posedge clk); #1;
      cyc++;
    end
    timed_out = !done;
    m_if.i_bin_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (m_if.o_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b want=0", m_if.o_ready); end
    n_cmp++; if (m_if.o_bin_valid !== 1'b0) begin n_bad++; $display("FAIL rst_bin_valid got=%b want=0", m_if.o_bin_valid); end
    n_cmp++; if (m_if.o_bin_index !== 8'd0) begin n_bad++; $display("FAIL rst_bin_index got=%0d want=0", m_if.o_bin_index); end
    n_cmp++; if (m_if.o_bin_count !== 16'd0) begin n_bad++; $display("FAIL rst_bin_count got=%0d want=0", m_if.o_bin_count); end
    n_cmp++; if (m_if.o_bin_last !== 1'b0) begin n_bad++; $display("FAIL rst_bin_last got=%b want=0", m_if.o_bin_last); end
    n_cmp++; if (m_if.o_total !== 24'd0) begin n_bad++; $display("FAIL rst_total got=%0d want=0", m_if.o_total); end
    n_cmp++; if (m_if.o_overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow got=%b want=0", m_if.o_overflow); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (m_if.o_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_release got=%b want=1", m_if.o_ready); end
  endtask

  task automatic test_full_frame();
    clear_exp();
    for (int v = 0; v < 10; v++) begin
      pix(8'(v), v == 9);
      exp_cnt[v] = 32'd1;
    end
    n_cmp++; if (m_if.o_ready !== 1'b0) begin n_bad++; $display("FAIL ff_ready_after_last got=%b want=0", m_if.o_ready); end
    n_cmp++; if (m_if.o_bin_valid !== 1'b0) begin n_bad++; $display("FAIL ff_valid_edge_k got=%b want=0", m_if.o_bin_valid); end
    capture_main(1'b0);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL ff_timeout got=%0d beats want=256", nbeats); end
    n_cmp++; if (nbeats !== 256) begin n_bad++; $display("FAIL ff_beats got=%0d want=256", nbeats); end
    n_cmp++; if (first_cyc !== 1) begin n_bad++; $display("FAIL ff_first_beat_latency got=%0d want=1", first_cyc); end
    n_cmp++; if (last_cyc - first_cyc !== 255) begin n_bad++; $display("FAIL ff_throughput got=%0d want=255", last_cyc - first_cyc); end
    for (int b = 0; b < 256; b++) begin
      n_cmp++; if (got_cnt[b] !== exp_cnt[b]) begin n_bad++; $display("FAIL ff_count[%0d] got=%0d want=%0d", b, got_cnt[b], exp_cnt[b]); end
      n_cmp++; if (got_idx[b] !== 32'(b)) begin n_bad++; $display("FAIL ff_index[%0d] got=%0d want=%0d", b, got_idx[b], b); end
      n_cmp++; if (got_last[b] !== (b == 255)) begin n_bad++; $display("FAIL ff_last[%0d] got=%b want=%b", b, got_last[b], b == 255); end
      n_cmp++; if (got_tot[b] !== 32'd10) begin n_bad++; $display("FAIL ff_total[%0d] got=%0d want=10", b, got_tot[b]); end
    end
    n_cmp++; if (m_if.o_bin_valid !== 1'b0) begin n_bad++; $display("FAIL ff_valid_after_m got=%b want=0", m_if.o_bin_valid); end
    n_cmp++; if (m_if.o_ready !== 1'b1) begin n_bad++; $display("FAIL ff_ready_after_m got=%b want=1", m_if.o_ready); end
    n_cmp++; if (m_if.o_total !== 24'd0) begin n_bad++; $display("FAIL ff_total_cleared got=%0d want=0", m_if.o_total); end
  endtask

  task automatic test_reset_mid_readout();
    int cyc;
    for (int i = 0; i < 5; i++) pix(8'd200, i == 4);
    m_if.i_bin_ready = 1'b1;
    cyc = 0;
    while (!(m_if.o_bin_valid === 1'b1 && m_if.o_bin_index === 8'd100) && cyc < 600) begin
      @(posedge clk); #1; cyc++;
    end
    n_cmp++; if (cyc >= 600) begin n_bad++; $display("FAIL rmr_reach_bin100 got=%0d cycles want<600", cyc); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (m_if.o_bin_valid !== 1'b0) begin n_bad++; $display("FAIL rmr_valid got=%b want=0", m_if.o_bin_valid); end
    n_cmp++; if (m_if.o_bin_index !== 8'd0) begin n_bad++; $display("FAIL rmr_index got=%0d want=0", m_if.o_bin_index); end
    n_cmp++; if (m_if.o_total !== 24'd0) begin n_bad++; $display("FAIL rmr_total got=%0d want=0", m_if.o_total); end
    n_cmp++; if (m_if.o_ready !== 1'b0) begin n_bad++; $display("FAIL rmr_ready got=%b want=0", m_if.o_ready); end
    m_if.i_bin_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (m_if.o_ready !== 1'b1) begin n_bad++; $display("FAIL rmr_ready_release got=%b want=1", m_if.o_ready); end
    clear_exp();
    exp_cnt[7] = 32'd3;
    pix(8'd7, 0); pix(8'd7, 0); pix(8'd7, 1);
    capture_main(1'b0);
    n_cmp++; if (nbeats !== 256) begin n_bad++; $display("FAIL rmr_beats got=%0d want=256", nbeats); end
    for (int b = 0; b < 256; b++) begin
      n_cmp++; if (got_cnt[b] !== exp_cnt[b]) begin n_bad++; $display("FAIL rmr_count[%0d] got=%0d want=%0d", b, got_cnt[b], exp_cnt[b]); end
    end
    n_cmp++; if (got_tot[0] !== 32'd3) begin n_bad++; $display("FAIL rmr_total got=%0d want=3", got_tot[0]); end
  endtask

  task automatic test_stall();
    clear_exp();
    exp_cnt[1] = 32'd2; exp_cnt[2] = 32'd1; exp_cnt[255] = 32'd1;
    pix(8'd1, 0); pix(8'd1, 0); pix(8'd2, 0); pix(8'd255, 1);
    capture_main(1'b1);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL st_timeout got=%0d beats want=256", nbeats); end
    n_cmp++; if (nbeats !== 256) begin n_bad++; $display("FAIL st_beats got=%0d want=256", nbeats); end
    n_cmp++; if (stall_moved) begin n_bad++; $display("FAIL st_stall_stable got=moved want=held"); end
    for (int b = 0; b < 256; b++) begin
      n_cmp++; if (got_idx[b] !== 32'(b)) begin n_bad++; $display("FAIL st_index[%0d] got=%0d want=%0d", b, got_idx[b], b); end
      n_cmp++; if (got_cnt[b] !== exp_cnt[b]) begin n_bad++; $display("FAIL st_count[%0d] got=%0d want=%0d", b, got_cnt[b], exp_cnt[b]); end
    end
    // Single-pixel follow-up frame: no residue from the stalled frame.
    clear_exp();
    exp_cnt[9] = 32'd1;
    pix(8'd9, 1);
    capture_main(1'b0);
    for (int b = 0; b < 256; b++) begin
      n_cmp++; if (got_cnt[b] !== exp_cnt[b]) begin n_bad++; $display("FAIL st2_count[%0d] got=%0d want=%0d", b, got_cnt[b], exp_cnt[b]); end
    end
    n_cmp++; if (got_tot[255] !== 32'd1) begin n_bad++; $display("FAIL st2_total got=%0d want=1", got_tot[255]); end
  endtask

  task automatic test_ignore_in_read();
    clear_exp();
    exp_cnt[3] = 32'd2;
    pix(8'd3, 0); pix(8'd3, 1);
    m_if.i_valid = 1'b1; m_if.i_data = 8'd3; m_if.i_last = 1'b0;
    capture_main(1'b0);
    m_if.i_valid = 1'b0;
    n_cmp++; if (ready_seen) begin n_bad++; $display("FAIL ir_ready_during_read got=1 want=0"); end
    n_cmp++; if (m_if.o_ready !== 1'b1) begin n_bad++; $display("FAIL ir_ready_after got=%b want=1", m_if.o_ready); end
    for (int b = 0; b < 256; b++) begin
      n_cmp++; if (got_cnt[b] !== exp_cnt[b]) begin n_bad++; $display("FAIL ir_count[%0d] got=%0d want=%0d", b, got_cnt[b], exp_cnt[b]); end
    end
    n_cmp++; if (got_tot[0] !== 32'd2) begin n_bad++; $display("FAIL ir_total got=%0d want=2", got_tot[0]); end
    clear_exp();
    exp_cnt[128] = 32'd1;
    pix(8'h80, 1);
    capture_main(1'b0);
    for (int b = 0; b < 256; b++) begin
      n_cmp++; if (got_cnt[b] !== exp_cnt[b]) begin n_bad++; $display("FAIL ir2_count[%0d] got=%0d want=%0d", b, got_cnt[b], exp_cnt[b]); end
    end
    n_cmp++; if (got_tot[0] !== 32'd1) begin n_bad++; $display("FAIL ir2_total got=%0d want=1", got_tot[0]); end
  endtask

  task automatic test_bin_bits4();
    logic [7:0]  vals [4];
    logic [31:0] cnt  [16];
    logic [31:0] want [16];
    logic        lst  [16];
    int cyc, nb;
    bit done;
    vals[0] = 8'h00; vals[1] = 8'h0F; vals[2] = 8'h10; vals[3] = 8'hFF;
    for (int b = 0; b < 16; b++) begin cnt[b] = 'x; lst[b] = 1'bx; want[b] = 32'd0; end
    want[0] = 32'd2; want[1] = 32'd1; want[15] = 32'd1;
    for (int i = 0; i < 4; i++) begin
      b_if.i_valid = 1'b1; b_if.i_data = vals[i]; b_if.i_last = (i == 3);
      @(posedge clk); #1;
    end
    b_if.i_valid = 1'b0; b_if.i_last = 1'b0;
    b_if.i_bin_ready = 1'b1;
    cyc = 0; nb = 0; done = 0;
    while (!done && cyc < 100 && nb < 20) begin
      if (b_if.o_bin_valid === 1'b1) begin
        if (nb < 16) begin cnt[nb] = 32'(b_if.o_bin_count); lst[nb] = b_if.o_bin_last; end
        n_cmp++; if (b_if.o_total !== 20'd4) begin n_bad++; $display("FAIL b4_total beat%0d got=%0d want=4", nb, b_if.o_total); end
        nb++;
        if (b_if.o_bin_last === 1'b1) done = 1;
      end
      @(posedge clk); #1; cyc++;
    end
    b_if.i_bin_ready = 1'b0;
    n_cmp++; if (nb !== 16) begin n_bad++; $display("FAIL b4_beats got=%0d want=16", nb); end
    for (int b = 0; b < 16; b++) begin
      n_cmp++; if (cnt[b] !== want[b]) begin n_bad++; $display("FAIL b4_count[%0d] got=%0d want=%0d", b, cnt[b], want[b]); end
      n_cmp++; if (lst[b] !== (b == 15)) begin n_bad++; $display("FAIL b4_last[%0d] got=%b want=%b", b, lst[b], b == 15); end
    end
  endtask

  task automatic test_count_w4();
    logic [31:0] bin5, want5;
    logic        want_ovf;
    int cyc, nb, nonzero;
    bit done;
`ifdef HIST_SATURATE_EN
    want5 = 32'd15; want_ovf = 1'b1;
`else
    want5 = 32'd4;  want_ovf = 1'b0;
`endif
    for (int i = 0; i < 20; i++) begin
      c_if.i_valid = 1'b1; c_if.i_data = 8'd5; c_if.i_last = (i == 19);
      @(posedge clk); #1;
    end
    c_if.i_valid = 1'b0; c_if.i_last = 1'b0;
    n_cmp++; if (c_if.o_overflow !== want_ovf) begin n_bad++; $display("FAIL c4_overflow got=%b want=%b", c_if.o_overflow, want_ovf); end
    c_if.i_bin_ready = 1'b1;
    cyc = 0; nb = 0; done = 0; nonzero = 0; bin5 = 'x;
    while (!done && cyc < 400 && nb < 300) begin
      if (c_if.o_bin_valid === 1'b1) begin
        if (c_if.o_bin_index === 8'd5) bin5 = 32'(c_if.o_bin_count);
        else if (c_if.o_bin_count !== 4'd0) nonzero++;
        if (nb == 0) begin
          n_cmp++; if (c_if.o_total !== 12'd20) begin n_bad++; $display("FAIL c4_total got=%0d want=20", c_if.o_total); end
        end
        nb++;
        if (c_if.o_bin_last === 1'b1) done = 1;
      end
      @(posedge clk); #1; cyc++;
    end
    c_if.i_bin_ready = 1'b0;
    n_cmp++; if (nb !== 256) begin n_bad++; $display("FAIL c4_beats got=%0d want=256", nb); end
    n_cmp++; if (bin5 !== want5) begin n_bad++; $display("FAIL c4_bin5 got=%0d want=%0d", bin5, want5); end
    n_cmp++; if (nonzero !== 0) begin n_bad++; $display("FAIL c4_other_bins got=%0d nonzero want=0", nonzero); end
    n_cmp++; if (c_if.o_overflow !== 1'b0) begin n_bad++; $display("FAIL c4_overflow_cleared got=%b want=0", c_if.o_overflow); end
  endtask

  initial begin
    rst_n = 1'b0;
    m_if.i_valid = 1'b0; m_if.i_data = '0; m_if.i_last = 1'b0; m_if.i_bin_ready = 1'b0;
    b_if.i_valid = 1'b0; b_if.i_data = '0; b_if.i_last = 1'b0; b_if.i_bin_ready = 1'b0;
    c_if.i_valid = 1'b0; c_if.i_data = '0; c_if.i_last = 1'b0; c_if.i_bin_ready = 1'b0;
    #12;
    test_reset();
    test_full_frame();
    test_reset_mid_readout();
    test_stall();
    test_ignore_in_read();
    test_bin_bits4();
    test_count_w4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
